// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite word memory with independent read/write FSMs; read data 1+R_DELAY cycles after AR, write commit and B 1+W_DELAY after the later of AW/W.
// Backpressure: R and B responses hold stable until RREADY/BREADY; no new address is accepted on a channel while its response is pending.
module axi4_lite_mem_slave #(
    parameter int MEM_DEPTH = 1024,
    parameter int R_DELAY   = 1,
    parameter int W_DELAY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY
);

    localparam int         AW    = $clog2(MEM_DEPTH);
    localparam logic [3:0] R_CNT = 4'(R_DELAY);
    localparam logic [3:0] W_CNT = 4'(W_DELAY);
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] DEC   = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem_q [MEM_DEPTH];

    function automatic logic addr_ok(input logic [31:0] a);
        return (a >> (AW + 2)) == 32'd0;
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state_q;
    logic [3:0]  r_cnt_q;
    logic [AW-1:0] ar_idx_q;
    logic        ar_ok_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        arready_q;
    logic        rvalid_q;

    logic          ar_fire;
    logic [AW-1:0] r_smp_idx;
    logic          r_smp_ok;
    logic [31:0]   r_smp_data;

    assign ar_fire = ARVALID & arready_q;

    // With zero read delay the sample comes straight off the AR bus.
    always_comb begin
        r_smp_idx = ar_idx_q;
        r_smp_ok  = ar_ok_q;
        if (r_state_q == R_IDLE) begin
            r_smp_idx = ARADDR[AW+1:2];
            r_smp_ok  = addr_ok(ARADDR);
        end
        r_smp_data = r_smp_ok ? mem_q[r_smp_idx] : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= 4'd0;
            ar_idx_q  <= '0;
            ar_ok_q   <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= OKAY;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        arready_q <= 1'b0;
                        ar_idx_q  <= ARADDR[AW+1:2];
                        ar_ok_q   <= addr_ok(ARADDR);
                        r_cnt_q   <= R_CNT;
                        if (R_DELAY == 0) begin
                            rdata_q   <= r_smp_data;
                            rresp_q   <= r_smp_ok ? OKAY : DEC;
                            rvalid_q  <= 1'b1;
                            r_state_q <= R_RESP;
                        end else begin
                            r_state_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q <= 4'd1) begin
                        rdata_q   <= r_smp_data;
                        rresp_q   <= r_smp_ok ? OKAY : DEC;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end else begin
                        r_cnt_q <= r_cnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    // ---------------- write channel ----------------
    w_state_t      w_state_q;
    logic [3:0]    w_cnt_q;
    logic          aw_got_q;
    logic          w_got_q;
    logic [AW-1:0] aw_idx_q;
    logic          aw_ok_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          awready_q;
    logic          wready_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;

    logic          aw_fire;
    logic          w_fire;
    logic          both_avail;
    logic          commit;
    logic [AW-1:0] c_idx;
    logic          c_ok;
    logic [31:0]   c_data;
    logic [3:0]    c_strb;

    assign aw_fire    = AWVALID & awready_q;
    assign w_fire     = WVALID & wready_q;
    assign both_avail = (aw_got_q | aw_fire) & (w_got_q | w_fire);

    // Commit operands come from the capture registers, or from the live bus
    // when a zero-delay write completes in the same cycle as its last handshake.
    always_comb begin
        c_idx  = aw_got_q ? aw_idx_q : AWADDR[AW+1:2];
        c_ok   = aw_got_q ? aw_ok_q  : addr_ok(AWADDR);
        c_data = w_got_q  ? wdata_q  : WDATA;
        c_strb = w_got_q  ? wstrb_q  : WSTRB;
        commit = 1'b0;
        if (rst) begin
            if (w_state_q == W_IDLE && W_DELAY == 0 && both_avail)
                commit = 1'b1;
            if (w_state_q == W_WAIT && w_cnt_q <= 4'd1)
                commit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= 4'd0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_got_q  <= 1'b1;
                        awready_q <= 1'b0;
                        aw_idx_q  <= AWADDR[AW+1:2];
                        aw_ok_q   <= addr_ok(AWADDR);
                    end
                    if (w_fire) begin
                        w_got_q  <= 1'b1;
                        wready_q <= 1'b0;
                        wdata_q  <= WDATA;
                        wstrb_q  <= WSTRB;
                    end
                    if (both_avail) begin
                        w_cnt_q <= W_CNT;
                        if (W_DELAY == 0) begin
                            bvalid_q  <= 1'b1;
                            bresp_q   <= c_ok ? OKAY : DEC;
                            w_state_q <= W_RESP;
                        end else begin
                            w_state_q <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt_q <= 4'd1) begin
                        bvalid_q  <= 1'b1;
                        bresp_q   <= c_ok ? OKAY : DEC;
                        w_state_q <= W_RESP;
                    end else begin
                        w_cnt_q <= w_cnt_q - 4'd1;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Storage has no reset; an aborted write never reaches this port.
    always_ff @(posedge clk) begin
        if (commit && c_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (c_strb[b])
                    mem_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed bench: instance 0 uses R_DELAY=1/W_DELAY=1, instance 1 uses R_DELAY=0/W_DELAY=4.
module tb_axi4_lite_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0][31:0] araddr, rdata, awaddr, wdata;
    logic [1:0]       arvalid, arready, rvalid, rready;
    logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0][1:0]  rresp, bresp;
    logic [1:0][3:0]  wstrb;

    int tests  = 0;
    int failed = 0;

    axi4_lite_mem_slave #(.MEM_DEPTH(1024), .R_DELAY(1), .W_DELAY(1)) dut_a (
        .clk(clk), .rst(rst[0]),
        .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
        .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0]),
        .AWADDR(awaddr[0]), .AWVALID(awvalid[0]), .AWREADY(awready[0]),
        .WDATA(wdata[0]), .WSTRB(wstrb[0]), .WVALID(wvalid[0]), .WREADY(wready[0]),
        .BRESP(bresp[0]), .BVALID(bvalid[0]), .BREADY(bready[0])
    );

    axi4_lite_mem_slave #(.MEM_DEPTH(1024), .R_DELAY(0), .W_DELAY(4)) dut_b (
        .clk(clk), .rst(rst[1]),
        .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
        .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1]),
        .AWADDR(awaddr[1]), .AWVALID(awvalid[1]), .AWREADY(awready[1]),
        .WDATA(wdata[1]), .WSTRB(wstrb[1]), .WVALID(wvalid[1]), .WREADY(wready[1]),
        .BRESP(bresp[1]), .BVALID(bvalid[1]), .BREADY(bready[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency is counted in cycles from the handshake cycle to the first BVALID cycle.
    task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int lat);
        awaddr[d] = addr;  awvalid[d] = 1'b1;
        wdata[d]  = data;  wstrb[d]   = strb;  wvalid[d] = 1'b1;
        tick();
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        lat = 1;
        while (!bvalid[d] && lat < 20) begin
            tick();
            lat++;
        end
        resp = bresp[d];
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
    endtask

    task automatic axi_read(input int d, input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        araddr[d] = addr; arvalid[d] = 1'b1;
        tick();
        arvalid[d] = 1'b0;
        lat = 1;
        while (!rvalid[d] && lat < 20) begin
            tick();
            lat++;
        end
        data = rdata[d];
        resp = rresp[d];
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;

        rst = 2'b11;
        araddr = '0; arvalid = '0; rready = '0;
        awaddr = '0; awvalid = '0; wdata = '0; wstrb = '0; wvalid = '0; bready = '0;
        #1 rst = 2'b00;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d rst ARREADY", d), arready[d], 1);
            check($sformatf("d%0d rst AWREADY", d), awready[d], 1);
            check($sformatf("d%0d rst WREADY", d), wready[d], 1);
            check($sformatf("d%0d rst RVALID", d), rvalid[d], 0);
            check($sformatf("d%0d rst BVALID", d), bvalid[d], 0);
            check($sformatf("d%0d rst RDATA", d), rdata[d], 0);
            check($sformatf("d%0d rst RRESP", d), rresp[d], 0);
            check($sformatf("d%0d rst BRESP", d), bresp[d], 0);
        end
        tick(); tick();
        rst = 2'b11;
        tick();

        // Full-word write and read back, latency 2 on both channels
        axi_write(0, 32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
        check("wr10 BRESP", resp, 0);
        check("wr10 latency", lat, 2);
        axi_read(0, 32'h10, data, resp, lat);
        check("rd10 RDATA", data, 32'hDEADBEEF);
        check("rd10 RRESP", resp, 0);
        check("rd10 latency", lat, 2);

        // Byte strobes
        axi_write(0, 32'h20, 32'h11223344, 4'hF, resp, lat);
        axi_write(0, 32'h20, 32'hAABBCCDD, 4'b0101, resp, lat);
        check("strb BRESP", resp, 0);
        axi_read(0, 32'h20, data, resp, lat);
        check("strb RDATA", data, 32'h11BB33DD);
        axi_write(0, 32'h20, 32'hFFFFFFFF, 4'b0000, resp, lat);
        check("strb0 BRESP", resp, 0);
        axi_read(0, 32'h20, data, resp, lat);
        check("strb0 RDATA", data, 32'h11BB33DD);

        // Low address bits ignored
        axi_read(0, 32'h13, data, resp, lat);
        check("rd13 RDATA", data, 32'hDEADBEEF);

        // W three cycles ahead of AW
        wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
        tick();
        wvalid[0] = 1'b0;
        check("wfirst WREADY", wready[0], 0);
        check("wfirst AWREADY", awready[0], 1);
        tick(); tick();
        check("wfirst BVALID early", bvalid[0], 0);
        awaddr[0] = 32'h8; awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        check("wfirst BVALID wait", bvalid[0], 0);
        tick();
        check("wfirst BVALID", bvalid[0], 1);
        check("wfirst BRESP", bresp[0], 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("wfirst BVALID hold %0d", i), bvalid[0], 1);
        end
        bready[0] = 1'b1;
        tick();
        bready[0] = 1'b0;
        check("wfirst BVALID drop", bvalid[0], 0);
        check("wfirst AWREADY back", awready[0], 1);
        check("wfirst WREADY back", wready[0], 1);
        tick();
        check("wfirst no 2nd pulse", bvalid[0], 0);
        axi_read(0, 32'h8, data, resp, lat);
        check("rd8 RDATA", data, 32'hCAFEF00D);

        // Address range boundaries
        axi_write(0, 32'h0, 32'h0BADF00D, 4'hF, resp, lat);
        axi_write(0, 32'hFFC, 32'h600DCAFE, 4'hF, resp, lat);
        check("wrFFC BRESP", resp, 0);
        axi_read(0, 32'hFFC, data, resp, lat);
        check("rdFFC RDATA", data, 32'h600DCAFE);
        check("rdFFC RRESP", resp, 0);
        axi_read(0, 32'h1000, data, resp, lat);
        check("rd1000 RRESP", resp, 3);
        check("rd1000 RDATA", data, 0);
        axi_write(0, 32'h1000, 32'h12345678, 4'hF, resp, lat);
        check("wr1000 BRESP", resp, 3);
        axi_read(0, 32'h0, data, resp, lat);
        check("rd0 RDATA", data, 32'h0BADF00D);
        check("rd0 RRESP", resp, 0);
        axi_read(0, 32'h80000010, data, resp, lat);
        check("rdhigh RRESP", resp, 3);

        // Read backpressure
        araddr[0] = 32'h10; arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp RVALID %0d", i), rvalid[0], 1);
            check($sformatf("bp RDATA %0d", i), rdata[0], 32'hDEADBEEF);
            check($sformatf("bp ARREADY %0d", i), arready[0], 0);
            tick();
        end
        rready[0] = 1'b1;
        tick();
        rready[0] = 1'b0;
        check("bp RVALID drop", rvalid[0], 0);
        check("bp ARREADY back", arready[0], 1);

        // Same-word read sample and write commit in one cycle
        axi_write(0, 32'h30, 32'h01010101, 4'hF, resp, lat);
        araddr[0] = 32'h30; arvalid[0] = 1'b1;
        awaddr[0] = 32'h30; awvalid[0] = 1'b1;
        wdata[0] = 32'h02020202; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        tick();
        check("coll RVALID", rvalid[0], 1);
        check("coll BVALID", bvalid[0], 1);
        check("coll RDATA old", rdata[0], 32'h01010101);
        rready[0] = 1'b1; bready[0] = 1'b1;
        tick();
        rready[0] = 1'b0; bready[0] = 1'b0;
        axi_read(0, 32'h30, data, resp, lat);
        check("coll RDATA new", data, 32'h02020202);

        // Second instance: zero read delay, four write wait cycles
        axi_write(1, 32'h40, 32'h55AA55AA, 4'hF, resp, lat);
        check("b wr40 BRESP", resp, 0);
        check("b wr40 latency", lat, 5);
        axi_read(1, 32'h40, data, resp, lat);
        check("b rd40 RDATA", data, 32'h55AA55AA);
        check("b rd40 latency", lat, 1);

        // Reset while the write is waiting
        awaddr[1] = 32'h40; awvalid[1] = 1'b1;
        wdata[1] = 32'h12121212; wstrb[1] = 4'hF; wvalid[1] = 1'b1;
        tick();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        tick();
        check("b inflight AWREADY", awready[1], 0);
        rst[1] = 1'b0;
        #1;
        check("b abort BVALID", bvalid[1], 0);
        check("b abort ARREADY", arready[1], 1);
        check("b abort AWREADY", awready[1], 1);
        check("b abort WREADY", wready[1], 1);
        repeat (6) tick();
        rst[1] = 1'b1;
        tick();
        check("b post BVALID", bvalid[1], 0);
        axi_read(1, 32'h40, data, resp, lat);
        check("b abort word", data, 32'h55AA55AA);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/axi4_lite_mem_slave.md
AXI4_LITE_MEM_SLAVE -- requirements
Module: axi4_lite_mem_slave

Interface
REQ-001 Parameters SHALL be:
- MEM_DEPTH, default 1024: number of 32-bit words; power of two, 2 or greater.
- R_DELAY, default 1: read wait cycles; range 0..15.
- W_DELAY, default 1: write wait cycles; range 0..15.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on posedge.
- rst, in, 1: reset, asynchronous and active-low.
- ARADDR, in, 32: read address.
- ARVALID, in, 1: read address valid.
- ARREADY, out, 1: read address ready.
- RDATA, out, 32: read data.
- RRESP, out, 2: read response.
- RVALID, out, 1: read data valid.
- RREADY, in, 1: read data ready.
- AWADDR, in, 32: write address.
- AWVALID, in, 1: write address valid.
- AWREADY, out, 1: write address ready.
- WDATA, in, 32: write data.
- WSTRB, in, 4: byte enables; bit i enables WDATA[8i+7:8i].
- WVALID, in, 1: write data valid.
- WREADY, out, 1: write data ready.
- BRESP, out, 2: write response.
- BVALID, out, 1: write response valid.
- BREADY, in, 1: write response ready.

Function
REQ-003 Storage SHALL be MEM_DEPTH x 32-bit words, indexed by addr[log2(MEM_DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-004 An address at or above 4*MEM_DEPTH SHALL be out of range: response 2'b11 (DECERR), no storage write, RDATA=32'h0.
REQ-005 In-range accesses SHALL respond 2'b00 (OKAY); no other response codes are produced.
REQ-006 Read FSM states SHALL be R_IDLE, R_WAIT, R_RESP:
- ARREADY=1 only in R_IDLE.
- AR handshake (ARVALID & ARREADY): latch ARADDR; go to R_WAIT if R_DELAY>0, else to R_RESP.
- R_WAIT counts R_DELAY cycles, then samples storage into RDATA/RRESP and goes to R_RESP.
REQ-007 In R_RESP, RVALID=1 and RDATA/RRESP SHALL hold stable until RREADY=1; that cycle returns to R_IDLE.
REQ-008 Read latency: AR handshake in cycle t SHALL give first RVALID=1 in cycle t+1+R_DELAY.
REQ-009 Write FSM states SHALL be W_IDLE, W_WAIT, W_RESP:
- In W_IDLE, AWREADY=1 until an AW is captured and WREADY=1 until a W is captured.
- AW and W are accepted in the same or different cycles, in either order.
REQ-010 When both AW and W are captured, the FSM SHALL go to W_WAIT for W_DELAY cycles (zero allowed), then in one cycle:
- commit the enabled WSTRB bytes of WDATA to storage (in range only);
- set BRESP;
- go to W_RESP.
REQ-011 Write latency: the later of the AW/W handshakes in cycle t SHALL give the storage update at posedge t+1+W_DELAY and BVALID=1 from cycle t+1+W_DELAY.
REQ-012 In W_RESP, BVALID=1 and BRESP SHALL hold until BREADY=1; that cycle returns to W_IDLE, clearing both capture flags.
REQ-013 Read and write FSMs SHALL run independently and concurrently.
REQ-014 If the read sample and the write commit target the same word in the same cycle, the read SHALL return the pre-write value.
REQ-015 WSTRB=4'b0000 SHALL leave storage unchanged and still produce BRESP=OKAY.
REQ-016 Delay counters SHALL be 4 bits wide and SHALL reload on every new transaction.
REQ-017 A valid input deasserted before its handshake SHALL have no effect; no transaction is dropped once its handshake completes.

Reset
REQ-018 When rst=0, asynchronously:
- both FSMs go to IDLE; capture flags and counters clear;
- ARREADY=1, AWREADY=1, WREADY=1;
- RVALID=0, BVALID=0, RDATA=0, RRESP=0, BRESP=0.
REQ-019 Storage contents SHALL NOT be reset.
REQ-020 Reset asserted mid-transaction SHALL abort it; a write not yet committed SHALL NOT modify storage.

Verification
REQ-021 Benches SHALL cover:
- R_DELAY=1, W_DELAY=1: write 0xDEADBEEF to 0x10 with WSTRB=4'hF, then read 0x10 -> BRESP=00, RDATA=0xDEADBEEF, RRESP=00, RVALID at AR cycle+2.
- Byte strobe: word 0x20 holds 0x11223344; write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
- W arrives 3 cycles before AW at address 0x8 -> single commit, one BVALID pulse held until BREADY.
- Out of range: with MEM_DEPTH=1024, read 0x1000 -> RRESP=11, RDATA=0; write 0x1000 -> BRESP=11 and word 0 unchanged.
- Backpressure: RREADY held low 5 cycles -> RVALID/RDATA stable, ARREADY=0 throughout.
- Reset at W_WAIT with W_DELAY=4 -> BVALID=0 immediately, target word unchanged, all READYs=1.
